// File: rtl/div_steps_param.sv
// Radix-2 restoring divider computing (dividend << FW) / divisor, one quotient
// bit per enabled clock, with signed/unsigned mode, remainder and error flags.
module div_steps_param #(
    parameter int unsigned DW = 32,
    parameter int unsigned VW = 32,
    parameter int unsigned FW = 32,
    parameter int unsigned QW = DW + FW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clk_en_i,
    input  logic          divide_i,
    input  logic          signed_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic [QW-1:0] quotient_o,
    output logic [VW-1:0] remainder_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          dz_o,
    output logic          ovf_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int unsigned   CW       = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);
    localparam logic [QW-1:0] Q_MAX    = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN    = {1'b1, {(QW-1){1'b0}}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic [QW-1:0] qr;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [VW-1:0] rem;
    logic [VW-1:0] dvs_mag;
    logic          neg_q;
    logic          neg_r;
    logic          dz_r;
    logic          sgn_r;

    logic [DW-1:0] dvd_abs;
    logic [VW-1:0] dvs_abs;
    logic [VW:0]   shifted;
    logic [VW+1:0] diff;
    logic          q_bit;
    logic [QW-1:0] q_res;
    logic [VW-1:0] r_res;
    logic          ovf_res;

    always_comb begin
        dvd_abs = (signed_i && dividend_i[DW-1]) ? -dividend_i : dividend_i;
        dvs_abs = (signed_i && divisor_i[VW-1])  ? -divisor_i  : divisor_i;
        shifted = {rem, qr[QW-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit   = ~diff[VW+1];
    end

    // Sign fix-up with divide-by-zero and signed-overflow saturation
    always_comb begin
        q_res   = neg_q ? -qr : qr;
        r_res   = neg_r ? -rem : rem;
        ovf_res = 1'b0;
        if (dz_r) begin
            r_res = '0;
            if (sgn_r) q_res = neg_r ? Q_MIN : Q_MAX;
            else       q_res = '1;
        end else if (sgn_r && (neg_q ? (qr[QW-1] && |qr[QW-2:0]) : qr[QW-1])) begin
            q_res   = neg_q ? Q_MIN : Q_MAX;
            ovf_res = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            qr          <= '0;
            rem         <= '0;
            dvs_mag     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_r        <= 1'b0;
            sgn_r       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            dz_o        <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (clk_en_i) begin
            case (state)
                IDLE: begin
                    if (divide_i) begin
                        qr      <= QW'(dvd_abs) << FW;
                        rem     <= '0;
                        dvs_mag <= dvs_abs;
                        neg_q   <= signed_i & (dividend_i[DW-1] ^ divisor_i[VW-1]);
                        neg_r   <= signed_i & dividend_i[DW-1];
                        dz_r    <= (divisor_i == '0);
                        sgn_r   <= signed_i;
                        done_o  <= 1'b0;
                        dz_o    <= 1'b0;
                        ovf_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        cnt     <= CNT_INIT;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    qr  <= {qr[QW-2:0], q_bit};
                    rem <= q_bit ? diff[VW-1:0] : shifted[VW-1:0];
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    quotient_o  <= q_res;
                    remainder_o <= r_res;
                    dz_o        <= dz_r;
                    ovf_o       <= ovf_res;
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_steps_param.sv
// Directed bench for div_steps_param at default parameters: vector table plus
// clock-enable jitter, ignored requests, back-to-back start and mid-run reset.
module tb_div_steps_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        divide = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] dvd = '0;
    logic [31:0] dvs = '0;
    logic [63:0] quotient;
    logic [31:0] remainder;
    logic        busy, done, dz, ovf;

    int errors = 0;
    int checks = 0;
    bit jitter = 1'b0;
    bit poke   = 1'b0;

    div_steps_param #(.DW(32), .VW(32), .FW(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clk_en_i   (clk_en),
        .divide_i   (divide),
        .signed_i   (sgn),
        .dividend_i (dvd),
        .divisor_i  (dvs),
        .quotient_o (quotient),
        .remainder_o(remainder),
        .busy_o     (busy),
        .done_o     (done),
        .dz_o       (dz),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request a division, then count enabled edges until done_o.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int acc_edges, output int lat, output int busy_n);
        int it;
        logic en_s;
        acc_edges = 0;
        lat       = 0;
        busy_n    = 0;
        @(negedge clk);
        dvd = a; dvs = b; sgn = s; divide = 1'b1; clk_en = 1'b1;
        while (acc_edges < 10) begin
            @(posedge clk);
            acc_edges++;
            #1;
            if (busy) break;
        end
        if (!busy) begin
            divide = 1'b0;
            return;
        end
        busy_n = 1;
        @(negedge clk);
        divide = 1'b0;
        it = 0;
        while (it < 1000) begin
            it++;
            if (jitter) clk_en = ($urandom_range(0, 1) == 1);
            if (poke && lat == 20) begin
                divide = 1'b1; dvd = 32'hDEAD_BEEF; dvs = 32'd7; sgn = 1'b1;
            end else begin
                divide = 1'b0;
            end
            @(posedge clk);
            en_s = clk_en;
            #1;
            if (en_s) begin
                lat++;
                if (busy) busy_n++;
            end
            if (done) break;
            @(negedge clk);
        end
        clk_en = 1'b1;
        divide = 1'b0;
    endtask

    initial begin
        int acc, lat, bn, seen;
        logic [63:0] num, gq, gr;

        vecs[0] = '{32'd2,         32'd1,         1'b0, 64'h00000002_00000000, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{32'd200,       32'd3,         1'b0, 64'h00000042_AAAAAAAA, 32'h2,        1'b0, 1'b0};
        vecs[2] = '{32'hFFFFFF38,  32'd3,         1'b1, 64'hFFFFFFBD_55555556, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3] = '{32'd5,         32'd0,         1'b0, 64'hFFFFFFFF_FFFFFFFF, 32'h0,        1'b1, 1'b0};
        vecs[4] = '{32'hFFFFFFFB,  32'd0,         1'b1, 64'h80000000_00000000, 32'h0,        1'b1, 1'b0};
        vecs[5] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h7FFFFFFF_FFFFFFFF, 32'h0,        1'b0, 1'b1};
        vecs[6] = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 64'h00000000_80000000, 32'h80000000, 1'b0, 1'b0};
        vecs[7] = '{32'd7,         32'hFFFFFFFE,  1'b1, 64'hFFFFFFFC_80000000, 32'h0,        1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFF,  32'd3,         1'b1, 64'hFFFFFFFF_AAAAAAAB, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9] = '{32'd0,         32'd0,         1'b1, 64'h7FFFFFFF_FFFFFFFF, 32'h0,        1'b1, 1'b0};

        #12;
        chk("reset_q",    quotient, 64'h0);
        chk("reset_r",    {32'h0, remainder}, 64'h0);
        chk("reset_flags", {60'h0, busy, done, dz, ovf}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].a, vecs[i].b, vecs[i].s, acc, lat, bn);
            chk($sformatf("v%0d_acc", i),  64'(acc), 64'd1);
            chk($sformatf("v%0d_q", i),    quotient, vecs[i].q);
            chk($sformatf("v%0d_r", i),    {32'h0, remainder}, {32'h0, vecs[i].r});
            chk($sformatf("v%0d_dz", i),   {63'h0, dz}, {63'h0, vecs[i].dz});
            chk($sformatf("v%0d_ovf", i),  {63'h0, ovf}, {63'h0, vecs[i].ovf});
            chk($sformatf("v%0d_lat", i),  64'(lat), 64'd65);
            chk($sformatf("v%0d_busy", i), 64'(bn), 64'd65);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {63'h0, done}, 64'h0);
            chk($sformatf("v%0d_flags_held", i), {62'h0, dz, ovf}, {62'h0, vecs[i].dz, vecs[i].ovf});
        end

        // Random clock-enable gaps must not change the result or enabled-edge latency
        jitter = 1'b1;
        run(32'd200, 32'd3, 1'b0, acc, lat, bn);
        jitter = 1'b0;
        chk("jit_q",    quotient, 64'h00000042_AAAAAAAA);
        chk("jit_r",    {32'h0, remainder}, 64'h2);
        chk("jit_lat",  64'(lat), 64'd65);
        chk("jit_busy", 64'(bn), 64'd65);
        @(posedge clk);
        #1;

        // New request and operand change mid-CALC are ignored
        poke = 1'b1;
        run(32'd200, 32'd3, 1'b0, acc, lat, bn);
        poke = 1'b0;
        chk("poke_q",   quotient, 64'h00000042_AAAAAAAA);
        chk("poke_r",   {32'h0, remainder}, 64'h2);
        chk("poke_lat", 64'(lat), 64'd65);

        // Back-to-back: request held through DONE is accepted one edge later
        num = {32'h40002000, 32'h0};
        gq  = num / 64'd13;
        gr  = num % 64'd13;
        run(32'h40002000, 32'd13, 1'b0, acc, lat, bn);
        chk("b2b_acc", 64'(acc), 64'd2);
        chk("b2b_q",   quotient, gq);
        chk("b2b_r",   {32'h0, remainder}, gr);
        chk("b2b_lat", 64'(lat), 64'd65);
        @(posedge clk);
        #1;

        // Asynchronous reset at CALC step 10 aborts with no done
        @(negedge clk);
        dvd = 32'd200; dvs = 32'd3; sgn = 1'b0; divide = 1'b1;
        @(posedge clk);
        @(negedge clk);
        divide = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_q",     quotient, 64'h0);
        chk("abort_r",     {32'h0, remainder}, 64'h0);
        chk("abort_flags", {60'h0, busy, done, dz, ovf}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run(32'd2, 32'd1, 1'b0, acc, lat, bn);
        chk("post_q",   quotient, 64'h00000002_00000000);
        chk("post_r",   {32'h0, remainder}, 64'h0);
        chk("post_lat", 64'(lat), 64'd65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
